// File: rtl/sub_abs_sched.sv
// Round-robin scheduler sharing one pipelined sub_abs_sub datapath among NREQ requesters.
// Optional SAS_PERF_CNT_EN adds saturating per-requester handshake counters (o_grant_cnt).
module sub_abs_sched #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int LAT  = 2,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NREQ-1:0]   i_req_valid,
    input  logic [NREQ*W-1:0] i_req_op1,
    input  logic [NREQ*W-1:0] i_req_op2,
    output logic [NREQ-1:0]   o_req_ready,
    output logic              o_dp_valid,
    output logic [W-1:0]      o_dp_op1,
    output logic [W-1:0]      o_dp_op2,
    input  logic [W-1:0]      i_dp_res,
    output logic              o_res_valid,
    output logic [IDW-1:0]    o_res_id,
    output logic [W-1:0]      o_res_data
`ifdef SAS_PERF_CNT_EN
    ,
    output logic [NREQ*16-1:0] o_grant_cnt
`endif
);

    logic [IDW-1:0] r_ptr;
    logic           r_dp_valid;
    logic [IDW-1:0] r_dp_id;
    logic [W-1:0]   r_dp_op1;
    logic [W-1:0]   r_dp_op2;
    logic           r_tv  [LAT];
    logic [IDW-1:0] r_tid [LAT];
    logic           r_res_valid;
    logic [IDW-1:0] r_res_id;
    logic [W-1:0]   r_res_data;

    logic           w_found;
    logic [IDW-1:0] w_gnt_id;
    logic [IDW-1:0] w_j;
    logic [W-1:0]   w_op1;
    logic [W-1:0]   w_op2;

    // Search begins one past the last winner so the previous winner ranks last.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_j      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_j = IDW'((int'(r_ptr) + k) % NREQ);
            if (!w_found && i_req_valid[w_j]) begin
                w_found  = 1'b1;
                w_gnt_id = w_j;
            end
        end
        if (i_rst) begin
            w_found = 1'b0;
        end
    end

    always_comb begin
        o_req_ready = '0;
        w_op1       = '0;
        w_op2       = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_found && w_gnt_id == IDW'(i)) begin
                o_req_ready[i] = 1'b1;
                w_op1          = i_req_op1[i*W +: W];
                w_op2          = i_req_op2[i*W +: W];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr       <= IDW'(NREQ - 1);
            r_dp_valid  <= 1'b0;
            r_dp_id     <= '0;
            r_dp_op1    <= '0;
            r_dp_op2    <= '0;
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_data  <= '0;
            for (int s = 0; s < LAT; s++) begin
                r_tv[s]  <= 1'b0;
                r_tid[s] <= '0;
            end
        end else begin
            r_dp_valid <= w_found;
            if (w_found) begin
                r_ptr    <= w_gnt_id;
                r_dp_id  <= w_gnt_id;
                r_dp_op1 <= w_op1;
                r_dp_op2 <= w_op2;
            end
            // Tag rides alongside the datapath so it exits with dp_res.
            r_tv[0]  <= r_dp_valid;
            r_tid[0] <= r_dp_id;
            for (int s = 1; s < LAT; s++) begin
                r_tv[s]  <= r_tv[s-1];
                r_tid[s] <= r_tid[s-1];
            end
            r_res_valid <= r_tv[LAT-1];
            if (r_tv[LAT-1]) begin
                r_res_id   <= r_tid[LAT-1];
                r_res_data <= i_dp_res;
            end
        end
    end

    assign o_dp_valid  = r_dp_valid;
    assign o_dp_op1    = r_dp_op1;
    assign o_dp_op2    = r_dp_op2;
    assign o_res_valid = r_res_valid;
    assign o_res_id    = r_res_id;
    assign o_res_data  = r_res_data;

`ifdef SAS_PERF_CNT_EN
    logic [15:0] r_cnt [NREQ];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREQ; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (o_req_ready[i] && r_cnt[i] != 16'hFFFF) begin
                    r_cnt[i] <= r_cnt[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        o_grant_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            o_grant_cnt[i*16 +: 16] = r_cnt[i];
        end
    end
`endif

endmodule
